// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Bundle of the fetch stage's memory, decoder and redirect
//               signals. The master modport is the fetch unit; the slave
//               modport is its environment (memory, decoder, branch unit).
//   Memory   : o_MemAddr, o_MemRead (out) / i_MemData (in)
//   Decoder  : o_Instr, o_InstrPC, o_Valid (out) / i_Ready (in)
//   Redirect : i_Redirect, i_Cond, i_Target, i_Z, i_S, i_C, i_OF (in)
//              o_Taken (out)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic [ADDR_W-1:0]  o_MemAddr;
   logic               o_MemRead;
   logic [INSTR_W-1:0] i_MemData;
   logic [INSTR_W-1:0] o_Instr;
   logic [ADDR_W-1:0]  o_InstrPC;
   logic               o_Valid;
   logic               i_Ready;
   logic               i_Redirect;
   logic [2:0]         i_Cond;
   logic [ADDR_W-1:0]  i_Target;
   logic               i_Z;
   logic               i_S;
   logic               i_C;
   logic               i_OF;
   logic               o_Taken;

   modport master (
      output o_MemAddr, o_MemRead, o_Instr, o_InstrPC, o_Valid, o_Taken,
      input  i_MemData, i_Ready, i_Redirect, i_Cond, i_Target,
             i_Z, i_S, i_C, i_OF
   );

   modport slave (
      input  o_MemAddr, o_MemRead, o_Instr, o_InstrPC, o_Valid, o_Taken,
      output i_MemData, i_Ready, i_Redirect, i_Cond, i_Target,
             i_Z, i_S, i_C, i_OF
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues reads to a
//               one-cycle-latency instruction memory, buffers returned words
//               in a 2-entry queue presented to the decoder (valid/ready),
//               and resolves flag-conditional redirects, flushing wrong-path
//               fetches.
//   i_CLK   : clock, rising edge
//   i_RST   : synchronous active-high reset
//   bus     : fetch_if.master (memory, decoder and redirect signals)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  wire logic i_CLK,
   input  wire logic i_RST,
   fetch_if.master   bus
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_rd_pc;       // address of the read now inflight
   logic [1:0]         r_occ;
   logic               r_inflight;
   logic               r_squash;
   logic               r_taken;
   logic [INSTR_W-1:0] r_q_instr [0:1]; // entry 0 is the head
   logic [ADDR_W-1:0]  r_q_pc    [0:1];

   logic               w_cond_true;
   logic               w_taken;
   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic [2:0]         w_need;
   logic [1:0]         w_base;

   // ------------------------------------------------------------------------
   // Redirect condition evaluation
   // ------------------------------------------------------------------------
   always_comb begin
      w_cond_true = 1'b0;
      case (bus.i_Cond)
         3'd0:    w_cond_true = 1'b1;
         3'd1:    w_cond_true = bus.i_Z;
         3'd2:    w_cond_true = !bus.i_Z;
         3'd3:    w_cond_true = bus.i_S;
         3'd4:    w_cond_true = bus.i_C;
         3'd5:    w_cond_true = !bus.i_C;
         3'd6:    w_cond_true = bus.i_OF;
         default: w_cond_true = 1'b0;
      endcase
   end

   assign w_taken = bus.i_Redirect && w_cond_true;
   assign w_pop   = (r_occ != 2'd0) && bus.i_Ready;

   // Entries that would be held after this cycle if a new read is added:
   // everything queued plus the word in flight, minus what leaves now.
   assign w_need  = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = !i_RST && !w_taken && (w_need < 3'd2);

   // A push landing in the same cycle as a taken redirect is wrong-path.
   assign w_push  = r_inflight && !r_squash && !w_taken;

   // Slot the pushed word goes into once the popped head has shifted out.
   assign w_base  = r_occ - {1'b0, w_pop};

   // ------------------------------------------------------------------------
   // Sequential update
   // ------------------------------------------------------------------------
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         r_pc         <= RESET_PC;
         r_rd_pc      <= '0;
         r_occ        <= 2'd0;
         r_inflight   <= 1'b0;
         r_squash     <= 1'b0;
         r_taken      <= 1'b0;
         r_q_instr[0] <= '0;
         r_q_instr[1] <= '0;
         r_q_pc[0]    <= '0;
         r_q_pc[1]    <= '0;
      end else begin
         r_taken    <= w_taken;
         r_squash   <= w_taken && r_inflight;
         r_inflight <= w_issue;

         if (w_taken) begin
            r_pc <= bus.i_Target;
         end else if (w_issue) begin
            r_pc <= r_pc + ADDR_W'(1);
         end

         if (w_issue) begin
            r_rd_pc <= r_pc;
         end

         if (w_taken) begin
            r_occ <= 2'd0;
         end else begin
            r_occ <= w_base + {1'b0, w_push};
            if (w_pop) begin
               r_q_instr[0] <= r_q_instr[1];
               r_q_pc[0]    <= r_q_pc[1];
            end
            // Later assignment overrides the shift when the push targets
            // the head slot.
            if (w_push) begin
               if (w_base == 2'd0) begin
                  r_q_instr[0] <= bus.i_MemData;
                  r_q_pc[0]    <= r_rd_pc;
               end else begin
                  r_q_instr[1] <= bus.i_MemData;
                  r_q_pc[1]    <= r_rd_pc;
               end
            end
         end
      end
   end

   // The issue rule keeps a push from ever meeting a full queue without a pop.
   always_ff @(posedge i_CLK) begin
      if (!i_RST && w_push && !w_pop) begin
         assert (r_occ != 2'd2);
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.o_MemAddr = r_pc;
   assign bus.o_MemRead = w_issue;
   assign bus.o_Instr   = r_q_instr[0];
   assign bus.o_InstrPC = r_q_pc[0];
   assign bus.o_Valid   = (r_occ != 2'd0);
   assign bus.o_Taken   = r_taken;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Directed timing
//               sequences, a condition-code vector table, and randomized
//               ready/redirect/reset traffic checked against an in-order
//               program-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic clk;
   logic rst;

   int n_cmp;
   int n_fail;

   fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus  ();
   fetch_if #(.ADDR_W(8), .INSTR_W(16)) bus2 ();

   fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus.master)
   );

   fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'hFE)) dut2 (
      .i_CLK (clk),
      .i_RST (rst),
      .bus   (bus2.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory, word[a] = {A5, a}
   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return {8'hA5, a};
   endfunction

   always @(posedge clk) begin
      if (bus.o_MemRead)  bus.i_MemData  <= mem_word(bus.o_MemAddr);
      if (bus2.o_MemRead) bus2.i_MemData <= mem_word(bus2.o_MemAddr);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Branch condition as stated for each code
   function automatic bit cond_ok(input logic [2:0] c, input logic z,
                                  input logic s, input logic cy, input logic of);
      case (c)
         3'd0:    return 1'b1;
         3'd1:    return z;
         3'd2:    return !z;
         3'd3:    return s;
         3'd4:    return cy;
         3'd5:    return !cy;
         3'd6:    return of;
         default: return 1'b0;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Reference model: the decoder must see the program stream in order,
   // sequential from RESET_PC, continuing from the target after every taken
   // redirect, with each word matching memory.
   // ------------------------------------------------------------------------
   logic [7:0] exp_pc;
   bit         have_prev;
   bit         prev_tk;
   bit         prev_rst;
   logic [7:0] prev_target;
   int         stall_cnt;

   initial begin
      have_prev = 0;
      prev_tk   = 0;
      prev_rst  = 0;
      exp_pc    = 8'h00;
      stall_cnt = 0;
   end

   always @(negedge clk) begin
      bit tk;
      tk = bus.i_Redirect && cond_ok(bus.i_Cond, bus.i_Z, bus.i_S, bus.i_C, bus.i_OF);
      if (have_prev) begin
         if (prev_rst) begin
            check("post_reset_valid", bus.o_Valid, 0);
            check("post_reset_taken", bus.o_Taken, 0);
         end else begin
            check("taken_pulse", bus.o_Taken, prev_tk);
            if (prev_tk) begin
               check("redir_valid_low", bus.o_Valid, 0);
               check("redir_addr", bus.o_MemAddr, prev_target);
               if (!rst && !tk) check("redir_issue", bus.o_MemRead, 1);
            end
         end
      end
      if (rst) begin
         check("rst_memread", bus.o_MemRead, 0);
         exp_pc    = 8'h00;
         stall_cnt = 0;
      end else begin
         if (tk) check("taken_no_issue", bus.o_MemRead, 0);
         if (bus.o_Valid && bus.i_Ready) begin
            check("stream_pc", bus.o_InstrPC, exp_pc);
            check("stream_instr", bus.o_Instr, mem_word(exp_pc));
            exp_pc    = exp_pc + 8'd1;
            stall_cnt = 0;
         end else if (bus.i_Ready) begin
            stall_cnt++;
            check("stream_live", stall_cnt > 2, 0);
            if (stall_cnt > 2) stall_cnt = 0;
         end
         if (tk) begin
            exp_pc    = bus.i_Target;
            stall_cnt = 0;
         end
      end
      prev_tk     = tk;
      prev_rst    = rst;
      prev_target = bus.i_Target;
      have_prev   = 1;
   end

   // ------------------------------------------------------------------------
   // Condition-code vector table
   // ------------------------------------------------------------------------
   typedef struct {
      logic [2:0] cond;
      logic       z;
      logic       s;
      logic       cy;
      logic       of;
      logic       exp_taken;
   } cond_vec_t;

   cond_vec_t vecs [16];

   initial begin
      vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      bus.i_Ready     = 1'b0;
      bus.i_Redirect  = 1'b0;
      bus.i_Cond      = 3'd0;
      bus.i_Target    = 8'h00;
      bus.i_Z = 1'b0; bus.i_S = 1'b0; bus.i_C = 1'b0; bus.i_OF = 1'b0;
      bus2.i_Ready    = 1'b1;
      bus2.i_Redirect = 1'b0;
      bus2.i_Cond     = 3'd0;
      bus2.i_Target   = 8'h00;
      bus2.i_Z = 1'b0; bus2.i_S = 1'b0; bus2.i_C = 1'b0; bus2.i_OF = 1'b0;

      // Reset values
      tick();
      tick();
      @(negedge clk);
      check("rst_valid", bus.o_Valid, 0);
      check("rst_instr", bus.o_Instr, 0);
      check("rst_instrpc", bus.o_InstrPC, 0);
      check("rst_taken", bus.o_Taken, 0);

      // Start-up latency and streaming; second instance starts at FE
      tick();
      bus.i_Ready = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("c0_memread", bus.o_MemRead, 1);
      check("c0_memaddr", bus.o_MemAddr, 8'h00);
      check("c0_memaddr_fe", bus2.o_MemAddr, 8'hFE);
      tick();
      @(negedge clk);
      check("c1_valid", bus.o_Valid, 0);
      check("c1_valid_fe", bus2.o_Valid, 0);
      for (int c = 2; c < 6; c++) begin
         logic [7:0] pc2;
         tick();
         @(negedge clk);
         pc2 = 8'hFE + 8'(c - 2);
         check("seq_valid", bus.o_Valid, 1);
         check("seq_pc", bus.o_InstrPC, 32'(c - 2));
         check("seq_instr", bus.o_Instr, {8'hA5, 8'(c - 2)});
         check("wrap_pc", bus2.o_InstrPC, pc2);
         check("wrap_instr", bus2.o_Instr, mem_word(pc2));
      end

      // Back-pressure from cycle 2 for 5 cycles
      tick();
      do_reset();
      tick();
      tick();
      bus.i_Ready = 1'b0;
      for (int k = 2; k < 7; k++) begin
         @(negedge clk);
         check("stall_valid", bus.o_Valid, 1);
         check("stall_head", bus.o_InstrPC, 0);
         check("stall_noread", bus.o_MemRead, 0);
         tick();
      end
      bus.i_Ready = 1'b1;
      @(negedge clk);
      check("release_issue", bus.o_MemRead, 1);
      for (int k = 0; k < 3; k++) begin
         check("release_pc", bus.o_InstrPC, k);
         tick();
         @(negedge clk);
      end

      // Unconditional redirect with a full queue
      tick();
      do_reset();
      tick();
      tick();
      bus.i_Ready = 1'b0;
      tick();
      tick();
      bus.i_Redirect = 1'b1;
      bus.i_Cond     = 3'd0;
      bus.i_Target   = 8'h40;
      @(negedge clk);
      check("rd_T_noread", bus.o_MemRead, 0);
      tick();
      bus.i_Redirect = 1'b0;
      @(negedge clk);
      check("rd_T1_taken", bus.o_Taken, 1);
      check("rd_T1_valid", bus.o_Valid, 0);
      check("rd_T1_read", bus.o_MemRead, 1);
      check("rd_T1_addr", bus.o_MemAddr, 8'h40);
      tick();
      @(negedge clk);
      check("rd_T2_taken", bus.o_Taken, 0);
      check("rd_T2_valid", bus.o_Valid, 0);
      tick();
      @(negedge clk);
      check("rd_T3_valid", bus.o_Valid, 1);
      check("rd_T3_pc", bus.o_InstrPC, 8'h40);
      check("rd_T3_instr", bus.o_Instr, 16'hA540);
      tick();
      bus.i_Ready = 1'b1;

      // Condition-code table while streaming
      for (int i = 0; i < 16; i++) begin
         logic [7:0] tgt;
         tgt = 8'h10 + 8'(i * 8);
         for (int k = 0; k < 4; k++) tick();
         bus.i_Redirect = 1'b1;
         bus.i_Cond     = vecs[i].cond;
         bus.i_Z        = vecs[i].z;
         bus.i_S        = vecs[i].s;
         bus.i_C        = vecs[i].cy;
         bus.i_OF       = vecs[i].of;
         bus.i_Target   = tgt;
         @(negedge clk);
         check("vec_issue", bus.o_MemRead, !vecs[i].exp_taken);
         tick();
         bus.i_Redirect = 1'b0;
         @(negedge clk);
         check("vec_taken", bus.o_Taken, vecs[i].exp_taken);
         if (vecs[i].exp_taken) check("vec_addr", bus.o_MemAddr, tgt);
      end

      // Reset mid-stream with the queue full
      for (int k = 0; k < 3; k++) tick();
      bus.i_Ready = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_noread", bus.o_MemRead, 0);
      tick();
      rst = 1'b0;
      bus.i_Ready = 1'b1;
      @(negedge clk);
      check("mid_c0_valid", bus.o_Valid, 0);
      check("mid_c0_taken", bus.o_Taken, 0);
      check("mid_c0_read", bus.o_MemRead, 1);
      check("mid_c0_addr", bus.o_MemAddr, 8'h00);
      tick();
      @(negedge clk);
      check("mid_c1_valid", bus.o_Valid, 0);
      tick();
      @(negedge clk);
      check("mid_c2_valid", bus.o_Valid, 1);
      check("mid_c2_pc", bus.o_InstrPC, 8'h00);

      // Randomized traffic checked by the stream model
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst            = ($urandom_range(0, 199) == 0);
         bus.i_Ready    = ($urandom_range(0, 9) < 7);
         bus.i_Redirect = ($urandom_range(0, 9) == 0);
         bus.i_Cond     = 3'($urandom_range(0, 7));
         bus.i_Z        = 1'($urandom_range(0, 1));
         bus.i_S        = 1'($urandom_range(0, 1));
         bus.i_C        = 1'($urandom_range(0, 1));
         bus.i_OF       = 1'($urandom_range(0, 1));
         bus.i_Target   = 8'($urandom_range(0, 255));
      end
      tick();
      rst = 1'b0;
      bus.i_Redirect = 1'b0;
      bus.i_Ready    = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
